btb_update_table: RTL and testbench

//  8-entry branch target buffer storage and update engine: the write side of the BTB whose flat
//  v/A/B/s buses feed the IF-stage prediction lookup. Learns from branches resolved in EX:

---
 rtl/btb_update_table_pkg.sv | 19 +
 rtl/btb_update_table_if.sv | 24 ++
 rtl/btb_update_table_sat_ctr2.sv | 19 +
 rtl/btb_update_table.sv | 145 ++++++++++++++
 tb/tb_btb_update_table.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/btb_update_table_pkg.sv
// Shared constants for the BTB update table: table geometry and the
// encodings of the 2-bit branch-direction counter.
package btb_update_table_pkg;

  localparam int ENTRIES = 8;
  localparam int IDX_W   = 3;

  // 2-bit saturating counter states; WT and ST predict taken.
  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  // Counter value written when a new branch is allocated (weakly taken).
  localparam logic [1:0] INIT_S_DEF = WT;

endpackage

// File: rtl/btb_update_table_if.sv
// Resolved-branch update bus from EX into the BTB update table.
//
// Handshake: upd_en is a valid-only strobe. One resolved branch is
// transferred on every rising clock edge where upd_en=1; there is no ready,
// the table always accepts. btb_clr is a level sampled on the same edge.
interface btb_update_table_if #(
  parameter int AW = 32
);
  logic          btb_clr;
  logic          upd_en;
  logic [AW-1:0] upd_pc;
  logic [AW-1:0] upd_target;
  logic          upd_taken;
  logic          upd_pred_tk;
  logic [AW-1:0] upd_pred_tgt;

  modport master (
    output btb_clr, upd_en, upd_pc, upd_target, upd_taken, upd_pred_tk, upd_pred_tgt
  );

  modport slave (
    input btb_clr, upd_en, upd_pc, upd_target, upd_taken, upd_pred_tk, upd_pred_tgt
  );
endinterface

// File: rtl/btb_update_table_sat_ctr2.sv
// 2-bit saturating up/down counter, next-state only (the register lives in
// the table so that clear/allocate/reset can all act on it in one place).
module btb_sat_ctr2 (
  input  logic [1:0] s,
  input  logic       up,
  output logic [1:0] s_nxt
);

  // Step toward ST on taken, toward SNT on not taken, hold at the rails.
  always_comb begin
    s_nxt = s;
    if (up) begin
      if (s != 2'b11) s_nxt = s + 2'd1;
    end else begin
      if (s != 2'b00) s_nxt = s - 2'd1;
    end
  end

endmodule

// File: rtl/btb_update_table.sv
// BTB storage and update engine. Learns from branches resolved in EX:
// trains counters and targets on a hit, allocates on a taken miss, and
// keeps saturating counts of branches and mispredicts. All outputs are
// registers; the flat v/A/B/s buses feed the IF-stage lookup.
module btb_update_table
  import btb_update_table_pkg::*;
#(
  parameter int         AW     = 32,
  parameter logic [1:0] INIT_S = INIT_S_DEF,
  parameter int         STAT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  btb_update_table_if.slave   upd,
  output logic                v1, v2, v3, v4, v5, v6, v7, v8,
  output logic [AW-1:0]       A1, A2, A3, A4, A5, A6, A7, A8,
  output logic [AW-1:0]       B1, B2, B3, B4, B5, B6, B7, B8,
  output logic [1:0]          s1, s2, s3, s4, s5, s6, s7, s8,
  output logic [STAT_W-1:0]   br_cnt,
  output logic [STAT_W-1:0]   mis_cnt
);

  logic             v_q   [ENTRIES];
  logic [AW-1:0]    a_q   [ENTRIES];
  logic [AW-1:0]    b_q   [ENTRIES];
  logic [1:0]       s_q   [ENTRIES];
  logic [1:0]       s_nxt [ENTRIES];
  logic [IDX_W-1:0] rr_ptr;

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             have_inv;
  logic [IDX_W-1:0] inv_idx;
  logic [IDX_W-1:0] victim_idx;
  logic             mispredict;

  // One counter next-state per entry; only the hit entry's result is used.
  for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
    btb_sat_ctr2 u_ctr (
      .s     (s_q[g]),
      .up    (upd.upd_taken),
      .s_nxt (s_nxt[g])
    );
  end

  // Hit search and first-free search; descending scan so lowest index wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    have_inv = 1'b0;
    inv_idx  = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (v_q[i] && (a_q[i] == upd.upd_pc)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!v_q[i]) begin
        have_inv = 1'b1;
        inv_idx  = IDX_W'(i);
      end
    end
    victim_idx = have_inv ? inv_idx : rr_ptr;
  end

  // Wrong direction, or taken to a different target than was fetched.
  assign mispredict = upd.upd_en &
                      ((upd.upd_taken != upd.upd_pred_tk) |
                       (upd.upd_taken & (upd.upd_pred_tgt != upd.upd_target)));

  // Table update: clear beats update; hit trains; taken miss allocates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        v_q[i] <= 1'b0;
        a_q[i] <= '0;
        b_q[i] <= '0;
        s_q[i] <= SNT;
      end
      rr_ptr <= '0;
    end else if (upd.btb_clr) begin
      for (int i = 0; i < ENTRIES; i++) v_q[i] <= 1'b0;
      rr_ptr <= '0;
    end else if (upd.upd_en) begin
      if (hit) begin
        s_q[hit_idx] <= s_nxt[hit_idx];
        if (upd.upd_taken) b_q[hit_idx] <= upd.upd_target;
      end else if (upd.upd_taken) begin
        v_q[victim_idx] <= 1'b1;
        a_q[victim_idx] <= upd.upd_pc;
        b_q[victim_idx] <= upd.upd_target;
        s_q[victim_idx] <= INIT_S;
        // Round-robin only advances when it actually picked the victim.
        if (!have_inv) rr_ptr <= rr_ptr + IDX_W'(1);
      end
    end
  end

  // Statistics count every resolved branch, including ones dropped by clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else begin
      if (upd.upd_en && (br_cnt != {STAT_W{1'b1}}))  br_cnt  <= br_cnt + 1'b1;
      if (mispredict && (mis_cnt != {STAT_W{1'b1}})) mis_cnt <= mis_cnt + 1'b1;
    end
  end

  assign v1 = v_q[0];
  assign v2 = v_q[1];
  assign v3 = v_q[2];
  assign v4 = v_q[3];
  assign v5 = v_q[4];
  assign v6 = v_q[5];
  assign v7 = v_q[6];
  assign v8 = v_q[7];

  assign A1 = a_q[0];
  assign A2 = a_q[1];
  assign A3 = a_q[2];
  assign A4 = a_q[3];
  assign A5 = a_q[4];
  assign A6 = a_q[5];
  assign A7 = a_q[6];
  assign A8 = a_q[7];

  assign B1 = b_q[0];
  assign B2 = b_q[1];
  assign B3 = b_q[2];
  assign B4 = b_q[3];
  assign B5 = b_q[4];
  assign B6 = b_q[5];
  assign B7 = b_q[6];
  assign B8 = b_q[7];

  assign s1 = s_q[0];
  assign s2 = s_q[1];
  assign s3 = s_q[2];
  assign s4 = s_q[3];
  assign s5 = s_q[4];
  assign s6 = s_q[5];
  assign s7 = s_q[6];
  assign s8 = s_q[7];

endmodule

// File: tb/tb_btb_update_table.sv
// Directed, table-driven bench for btb_update_table.
module tb_btb_update_table;

  logic clk;
  logic rst_n;

  btb_update_table_if #(.AW(32)) u_if ();

  logic        v1, v2, v3, v4, v5, v6, v7, v8;
  logic [31:0] A1, A2, A3, A4, A5, A6, A7, A8;
  logic [31:0] B1, B2, B3, B4, B5, B6, B7, B8;
  logic [1:0]  s1, s2, s3, s4, s5, s6, s7, s8;
  logic [15:0] br_cnt, mis_cnt;

  btb_update_table #(.AW(32), .INIT_S(2'b10), .STAT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .upd(u_if.slave),
    .v1(v1), .v2(v2), .v3(v3), .v4(v4), .v5(v5), .v6(v6), .v7(v7), .v8(v8),
    .A1(A1), .A2(A2), .A3(A3), .A4(A4), .A5(A5), .A6(A6), .A7(A7), .A8(A8),
    .B1(B1), .B2(B2), .B3(B3), .B4(B4), .B5(B5), .B6(B6), .B7(B7), .B8(B8),
    .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5), .s6(s6), .s7(s7), .s8(s8),
    .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  // Flat outputs gathered into arrays for indexed checking.
  logic        v_t [8];
  logic [31:0] a_t [8];
  logic [31:0] b_t [8];
  logic [1:0]  s_t [8];
  assign v_t[0] = v1; assign v_t[1] = v2; assign v_t[2] = v3; assign v_t[3] = v4;
  assign v_t[4] = v5; assign v_t[5] = v6; assign v_t[6] = v7; assign v_t[7] = v8;
  assign a_t[0] = A1; assign a_t[1] = A2; assign a_t[2] = A3; assign a_t[3] = A4;
  assign a_t[4] = A5; assign a_t[5] = A6; assign a_t[6] = A7; assign a_t[7] = A8;
  assign b_t[0] = B1; assign b_t[1] = B2; assign b_t[2] = B3; assign b_t[3] = B4;
  assign b_t[4] = B5; assign b_t[5] = B6; assign b_t[6] = B7; assign b_t[7] = B8;
  assign s_t[0] = s1; assign s_t[1] = s2; assign s_t[2] = s3; assign s_t[3] = s4;
  assign s_t[4] = s5; assign s_t[5] = s6; assign s_t[6] = s7; assign s_t[7] = s8;

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  typedef struct {
    logic        clr;
    logic        en;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        taken;
    logic        ptk;
    logic [31:0] ptgt;
    int          idx;
    logic        ev;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [1:0]  es;
    logic [15:0] ebr;
    logic [15:0] emis;
  } vec_t;

  localparam int NV = 22;
  vec_t vec [NV];

  function automatic vec_t mk(input logic clr, en, input logic [31:0] pc, tgt,
                              input logic taken, ptk, input logic [31:0] ptgt,
                              input int idx, input logic ev, input logic [31:0] ea, eb,
                              input logic [1:0] es, input logic [15:0] ebr, emis);
    vec_t t;
    t.clr = clr; t.en = en; t.pc = pc; t.tgt = tgt; t.taken = taken;
    t.ptk = ptk; t.ptgt = ptgt; t.idx = idx; t.ev = ev; t.ea = ea;
    t.eb = eb; t.es = es; t.ebr = ebr; t.emis = emis;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Driver: present one record, let one edge sample it, settle past the edge.
  task automatic drive(input logic clr, en, input logic [31:0] pc, tgt,
                       input logic taken, ptk, input logic [31:0] ptgt);
    u_if.btb_clr      = clr;
    u_if.upd_en       = en;
    u_if.upd_pc       = pc;
    u_if.upd_target   = tgt;
    u_if.upd_taken    = taken;
    u_if.upd_pred_tk  = ptk;
    u_if.upd_pred_tgt = ptgt;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_reset(input string tag);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_v%0d", tag, i + 1), 64'(v_t[i]), 64'd0);
      check($sformatf("%s_a%0d", tag, i + 1), 64'(a_t[i]), 64'd0);
      check($sformatf("%s_s%0d", tag, i + 1), 64'(s_t[i]), 64'd0);
    end
    check({tag, "_br"},  64'(br_cnt),  64'd0);
    check({tag, "_mis"}, 64'(mis_cnt), 64'd0);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;

    // Vector table (entry index 0 is entry 1).
    vec[0]  = mk(0,1,'h40,'h80,1,0,'h0,    0, 1,'h40,'h80,2,  1,1); // alloc, dir mispredict
    vec[1]  = mk(0,1,'h44,'h88,0,0,'h0,    1, 0,'h0,'h0,0,    2,1); // NT miss: no change
    vec[2]  = mk(0,1,'h40,'h80,1,1,'h80,   0, 1,'h40,'h80,3,  3,1);
    vec[3]  = mk(0,1,'h40,'h80,1,1,'h80,   0, 1,'h40,'h80,3,  4,1); // saturated high
    vec[4]  = mk(0,1,'h40,'h80,1,1,'h80,   0, 1,'h40,'h80,3,  5,1);
    vec[5]  = mk(0,1,'h40,'h80,0,1,'h80,   0, 1,'h40,'h80,2,  6,2);
    vec[6]  = mk(0,1,'h40,'h80,0,0,'h0,    0, 1,'h40,'h80,1,  7,2);
    vec[7]  = mk(0,1,'h40,'h80,0,0,'h0,    0, 1,'h40,'h80,0,  8,2);
    vec[8]  = mk(0,1,'h40,'h80,0,0,'h0,    0, 1,'h40,'h80,0,  9,2); // saturated low
    vec[9]  = mk(0,0,'h40,'h99,1,0,'h0,    0, 1,'h40,'h80,0,  9,2); // idle: hold
    vec[10] = mk(0,1,'h40,'h90,1,1,'h80,   0, 1,'h40,'h90,1, 10,3); // target mispredict
    for (int k = 0; k < 7; k++)
      vec[11+k] = mk(0,1,32'h100+32'(4*k),32'h1100+32'(4*k),1,1,32'h1100+32'(4*k),
                     k+1, 1,32'h100+32'(4*k),32'h1100+32'(4*k),2, 16'(11+k),3);
    vec[18] = mk(0,1,'h200,'h300,1,0,'h0,  0, 1,'h200,'h300,2, 18,4); // rr victim entry1
    vec[19] = mk(0,1,'h204,'h304,1,0,'h0,  1, 1,'h204,'h304,2, 19,5); // rr victim entry2
    vec[20] = mk(1,1,'h208,'h308,1,0,'h0,  2, 0,'h104,'h1104,2, 20,6); // clr wins
    vec[21] = mk(0,1,'h208,'h308,1,1,'h308,0, 1,'h208,'h308,2, 21,6); // first free after clr

    rst_n = 1'b0;
    u_if.btb_clr = 0; u_if.upd_en = 0; u_if.upd_pc = 0; u_if.upd_target = 0;
    u_if.upd_taken = 0; u_if.upd_pred_tk = 0; u_if.upd_pred_tgt = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < NV; n++) begin
      drive(vec[n].clr, vec[n].en, vec[n].pc, vec[n].tgt, vec[n].taken, vec[n].ptk, vec[n].ptgt);
      check($sformatf("vec%0d_v",   n), 64'(v_t[vec[n].idx]), 64'(vec[n].ev));
      check($sformatf("vec%0d_a",   n), 64'(a_t[vec[n].idx]), 64'(vec[n].ea));
      check($sformatf("vec%0d_b",   n), 64'(b_t[vec[n].idx]), 64'(vec[n].eb));
      check($sformatf("vec%0d_s",   n), 64'(s_t[vec[n].idx]), 64'(vec[n].es));
      check($sformatf("vec%0d_br",  n), 64'(br_cnt),          64'(vec[n].ebr));
      check($sformatf("vec%0d_mis", n), 64'(mis_cnt),         64'(vec[n].emis));
    end

    // Clear must also rewind rr_ptr: refill, then the next miss replaces entry1.
    for (int k = 0; k < 7; k++)
      drive(0, 1, 32'h500 + 32'(4*k), 32'h600 + 32'(4*k), 1, 1, 32'h600 + 32'(4*k));
    drive(0, 1, 32'h400, 32'h480, 1, 1, 32'h480);
    check("rr_after_clr_a1", 64'(a_t[0]), 64'h400);
    check("rr_after_clr_b1", 64'(b_t[0]), 64'h480);
    check("rr_after_clr_s1", 64'(s_t[0]), 64'd2);
    check("rr_after_clr_a3", 64'(a_t[2]), 64'h504);
    check("rr_after_clr_a8", 64'(a_t[7]), 64'h518);
    check("rr_after_clr_br", 64'(br_cnt), 64'd29);
    check("rr_after_clr_mis", 64'(mis_cnt), 64'd6);
    u_if.upd_en = 0;

    // Mid-run asynchronous reset: visible before the next clock edge.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    // Saturation: more branches than br_cnt can hold, none mispredicted.
    for (int k = 0; k < 65540; k++) begin
      u_if.btb_clr = 0; u_if.upd_en = 1; u_if.upd_pc = 32'h44; u_if.upd_target = 32'h88;
      u_if.upd_taken = 0; u_if.upd_pred_tk = 0; u_if.upd_pred_tgt = 0;
      @(posedge clk);
    end
    #1;
    u_if.upd_en = 0;
    check("sat_br",  64'(br_cnt),  64'hFFFF);
    check("sat_mis", 64'(mis_cnt), 64'd0);
    check("sat_v1",  64'(v_t[0]),  64'd0);
    drive(0, 1, 32'h44, 32'h88, 0, 0, 32'h0);
    check("sat_br_hold", 64'(br_cnt), 64'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
